// File: rtl/lsu_mem_initiator_pkg.sv
// Shared constants, FSM encoding and the alignment helper for the load/store initiator.
package lsu_mem_initiator_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Halfwords need addr[0]=0, words (size 10 or 11) need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SIZE_BYTE) begin
      return 1'b0;
    end else if (size == SIZE_HWORD) begin
      return addr_lo[0];
    end else begin
      return |addr_lo;
    end
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake plus the byte-addressed memory port, bundled for the initiator.
interface lsu_mem_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_wdata;
  logic        mem_wen_n;
  logic [31:0] mem_rdata;

  // The initiator itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_sign, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_size, mem_sign, mem_wdata, mem_wen_n
  );

  // The pipeline and memory surrounding the initiator.
  modport master (
    output req_valid, req_write, req_addr, req_size, req_sign, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_size, mem_sign, mem_wdata, mem_wen_n
  );

endinterface

// File: rtl/lsu_load_assemble.sv
// Merges one byte beat into the split-load lanes and extends the merged value.
module lsu_load_assemble
  import lsu_mem_initiator_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] lanes,
  input  logic [1:0]  idx,
  input  logic [7:0]  byte_in,
  output logic [31:0] merged,
  output logic [31:0] result
);

  // Drop the new byte into lane idx; halfwords extend from bit 15, words pass through.
  always_comb begin
    merged = lanes;
    merged[{idx, 3'b000} +: 8] = byte_in;
    if (size == SIZE_HWORD) begin
      result = {{16{sign & merged[15]}}, merged[15:0]};
    end else begin
      result = merged;
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, aligned accesses in a single memory beat,
// misaligned halfword/word accesses split into byte beats (or rejected).
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  lsu_mem_initiator_if.slave bus
);

  state_t      state, state_n;
  logic        write_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] wdata_q;
  logic        split_q;
  logic [1:0]  beat_q;
  logic [1:0]  last_q;
  logic [31:0] lanes_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        mis;
  logic [31:0] merged;
  logic [31:0] assembled;

  assign mis    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign accept = (state == ST_IDLE) && bus.req_valid;

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  lsu_load_assemble u_assemble (
    .size    (size_q),
    .sign    (sign_q),
    .lanes   (lanes_q),
    .idx     (beat_q),
    .byte_in (bus.mem_rdata[7:0]),
    .merged  (merged),
    .result  (assembled)
  );

  // State register; reset abandons any remaining beats without a response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, handshake outputs and memory port drive; the port idles outside BEAT.
  always_comb begin
    state_n       = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_size  = SIZE_BYTE;
    bus.mem_sign  = 1'b0;
    bus.mem_wdata = 32'd0;
    bus.mem_wen_n = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_n = (mis && !ALLOW_MISALIGNED) ? ST_RESP : ST_BEAT;
        end
      end
      ST_BEAT: begin
        bus.mem_wen_n = ~write_q;
        if (split_q) begin
          bus.mem_addr  = addr_q + {30'd0, beat_q};
          bus.mem_wdata = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
        end else begin
          bus.mem_addr  = addr_q;
          bus.mem_size  = size_q;
          bus.mem_sign  = sign_q;
          bus.mem_wdata = wdata_q;
        end
        if (beat_q == last_q) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch, beat counter, lane capture and the held response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_q      <= 2'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      write_q     <= bus.req_write;
      addr_q      <= bus.req_addr;
      size_q      <= bus.req_size;
      sign_q      <= bus.req_sign;
      wdata_q     <= bus.req_wdata;
      split_q     <= mis;
      beat_q      <= 2'd0;
      last_q      <= !mis ? 2'd0 : (bus.req_size == SIZE_HWORD) ? 2'd1 : 2'd3;
      lanes_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= mis && !ALLOW_MISALIGNED;
    end else if (state == ST_BEAT) begin
      beat_q  <= beat_q + 2'd1;
      lanes_q <= merged;
      if (beat_q == last_q) begin
        rsp_rdata_q <= write_q ? 32'd0 : (split_q ? assembled : bus.mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte memory model and a response scoreboard.
module tb_lsu_mem_initiator;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  rsp_t sb[$];

  logic [7:0] mem [0:1023];
  bit         preload_done;
  int         rej_wen_cnt;
  int         rej_addr_cnt;

  lsu_mem_initiator_if ifa ();
  lsu_mem_initiator_if ifr ();

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b1)) dut_a (.CLK(clk), .RST(rst), .bus(ifa.slave));
  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b0)) dut_r (.CLK(clk), .RST(rst), .bus(ifr.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read: combinational, extension applied by the memory itself per size/sign.
  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [9:0] i;
    i = a[9:0];
    case (sz)
      2'b00:   mem_read = {{24{sg & mem[i][7]}}, mem[i]};
      2'b01:   mem_read = {{16{sg & mem[i + 10'd1][7]}}, mem[i + 10'd1], mem[i]};
      default: mem_read = {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
    endcase
  endfunction

  assign ifa.mem_rdata = mem_read(ifa.mem_addr, ifa.mem_size, ifa.mem_sign);
  assign ifr.mem_rdata = mem_read(ifr.mem_addr, ifr.mem_size, ifr.mem_sign);

  // Memory writes on the falling edge while WEN is low; also watches the rejecting instance.
  always @(negedge clk) begin
    if (!preload_done) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
      mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33;
      mem[10'h103] <= 8'h84; mem[10'h104] <= 8'h55; mem[10'h105] <= 8'h66;
      preload_done <= 1'b1;
    end else begin
      if (ifa.mem_wen_n === 1'b0) begin
        mem[ifa.mem_addr[9:0]] <= ifa.mem_wdata[7:0];
        if (ifa.mem_size != 2'b00) mem[ifa.mem_addr[9:0] + 10'd1] <= ifa.mem_wdata[15:8];
        if (ifa.mem_size[1]) begin
          mem[ifa.mem_addr[9:0] + 10'd2] <= ifa.mem_wdata[23:16];
          mem[ifa.mem_addr[9:0] + 10'd3] <= ifa.mem_wdata[31:24];
        end
      end
    end
    if (ifr.mem_wen_n !== 1'b1) rej_wen_cnt <= rej_wen_cnt + 1;
    if (ifr.mem_addr !== 32'd0) rej_addr_cnt <= rej_addr_cnt + 1;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One request on the splitting instance: beat-by-beat port checks, optional backpressure,
  // then the response popped from the scoreboard at retirement.
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int beats, input logic [1:0] msz,
                         input int hold);
    rsp_t e;
    chk1({tag, "_req_ready_idle"}, ifa.req_ready, 1'b1);
    ifa.req_valid = 1'b1;
    ifa.req_write = wr;
    ifa.req_addr  = addr;
    ifa.req_size  = sz;
    ifa.req_sign  = sg;
    ifa.req_wdata = wd;
    sb.push_back('{rd: exp_rd, err: 1'b0});
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      chk1({tag, "_beat_rsp_valid"}, ifa.rsp_valid, 1'b0);
      chk1({tag, "_beat_req_ready"}, ifa.req_ready, 1'b0);
      chk1({tag, "_beat_wen_n"}, ifa.mem_wen_n, ~wr);
      chk32({tag, "_beat_addr"}, ifa.mem_addr, addr + 32'(b));
      chk32({tag, "_beat_size"}, {30'd0, ifa.mem_size}, {30'd0, msz});
      chk32({tag, "_beat_wdata"}, ifa.mem_wdata, (beats > 1) ? {24'd0, wd[8*b +: 8]} : wd);
      @(posedge clk); #1;
    end
    chk1({tag, "_rsp_valid_latency"}, ifa.rsp_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      chk32({tag, "_hold_rdata"}, ifa.rsp_rdata, exp_rd);
      chk1({tag, "_hold_req_ready"}, ifa.req_ready, 1'b0);
      chk1({tag, "_hold_wen_n"}, ifa.mem_wen_n, 1'b1);
      chk32({tag, "_hold_mem_addr"}, ifa.mem_addr, 32'd0);
      @(posedge clk); #1;
      chk1({tag, "_hold_rsp_valid"}, ifa.rsp_valid, 1'b1);
    end
    ifa.rsp_ready = 1'b1;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk32({tag, "_rdata"}, ifa.rsp_rdata, e.rd);
      chk1({tag, "_err"}, ifa.rsp_err, e.err);
    end
    @(posedge clk); #1;
    ifa.rsp_ready = 1'b0;
    chk1({tag, "_retired"}, ifa.rsp_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wen0, addr0;
    rsp_t e;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = 32'd0; ifa.req_size = 2'b00;
    ifa.req_sign = 1'b0; ifa.req_wdata = 32'd0; ifa.rsp_ready = 1'b0;
    ifr.req_valid = 1'b0; ifr.req_write = 1'b0; ifr.req_addr = 32'd0; ifr.req_size = 2'b00;
    ifr.req_sign = 1'b0; ifr.req_wdata = 32'd0; ifr.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req_ready", ifa.req_ready, 1'b1);
    chk1("rst_rsp_valid", ifa.rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
    chk1("rst_rsp_err", ifa.rsp_err, 1'b0);
    chk1("rst_wen_n", ifa.mem_wen_n, 1'b1);
    chk32("rst_mem_addr", ifa.mem_addr, 32'd0);
    chk32("rst_mem_wdata", ifa.mem_wdata, 32'd0);
    chk1("rst_rej_req_ready", ifr.req_ready, 1'b1);
    rst = 1'b0;

    run_req("ld_w_100",   1'b0, 32'h100, 2'b10, 1'b0, 32'd0, 32'h84332211, 1, 2'b10, 0);
    run_req("ld_b_103_s", 1'b0, 32'h103, 2'b00, 1'b1, 32'd0, 32'hFFFFFF84, 1, 2'b00, 0);
    run_req("ld_b_103_u", 1'b0, 32'h103, 2'b00, 1'b0, 32'd0, 32'h00000084, 1, 2'b00, 0);
    run_req("ld_h_102_s", 1'b0, 32'h102, 2'b01, 1'b1, 32'd0, 32'hFFFF8433, 1, 2'b01, 0);
    run_req("ld_h_101_s", 1'b0, 32'h101, 2'b01, 1'b1, 32'd0, 32'h00003322, 2, 2'b00, 0);
    run_req("ld_w_102",   1'b0, 32'h102, 2'b10, 1'b0, 32'd0, 32'h66558433, 4, 2'b00, 3);
    run_req("st_w_201",   1'b1, 32'h201, 2'b10, 1'b0, 32'hAABBCCDD, 32'd0, 4, 2'b00, 0);
    chk32("st_w_201_m201", {24'd0, mem[10'h201]}, 32'h0000_00DD);
    chk32("st_w_201_m202", {24'd0, mem[10'h202]}, 32'h0000_00CC);
    chk32("st_w_201_m203", {24'd0, mem[10'h203]}, 32'h0000_00BB);
    chk32("st_w_201_m204", {24'd0, mem[10'h204]}, 32'h0000_00AA);
    run_req("ld_w_200",   1'b0, 32'h200, 2'b10, 1'b0, 32'd0, 32'hBBCCDD00, 1, 2'b10, 0);
    run_req("ld_h_203_s", 1'b0, 32'h203, 2'b01, 1'b1, 32'd0, 32'hFFFFAABB, 2, 2'b00, 0);
    run_req("ld_h_203_u", 1'b0, 32'h203, 2'b01, 1'b0, 32'd0, 32'h0000AABB, 2, 2'b00, 0);
    run_req("ld_w_wrap",  1'b0, 32'hFFFFFFFF, 2'b11, 1'b0, 32'd0, 32'd0, 4, 2'b00, 0);
    run_req("st_b_210",   1'b1, 32'h210, 2'b00, 1'b0, 32'h000000C7, 32'd0, 1, 2'b00, 1);
    chk32("st_b_210_mem", {24'd0, mem[10'h210]}, 32'h0000_00C7);

    // Reset during the second beat of a split store at 0x301.
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h301;
    ifa.req_size = 2'b10; ifa.req_sign = 1'b0; ifa.req_wdata = 32'h44332211;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    chk32("rstmid_beat0_addr", ifa.mem_addr, 32'h301);
    chk1("rstmid_beat0_wen_n", ifa.mem_wen_n, 1'b0);
    @(posedge clk); #1;
    chk32("rstmid_beat1_addr", ifa.mem_addr, 32'h302);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("rstmid_req_ready", ifa.req_ready, 1'b1);
    chk1("rstmid_wen_n", ifa.mem_wen_n, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk1("rstmid_no_rsp", ifa.rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    chk32("rstmid_m301", {24'd0, mem[10'h301]}, 32'h0000_0011);
    chk32("rstmid_m302", {24'd0, mem[10'h302]}, 32'h0000_0022);
    chk32("rstmid_m303", {24'd0, mem[10'h303]}, 32'h0000_0000);
    chk32("rstmid_m304", {24'd0, mem[10'h304]}, 32'h0000_0000);
    run_req("post_rst_ld_w_100", 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, 32'h84332211, 1, 2'b10, 0);

    // Rejecting instance: misaligned word load must not touch memory.
    wen0  = rej_wen_cnt;
    addr0 = rej_addr_cnt;
    ifr.req_valid = 1'b1; ifr.req_write = 1'b0; ifr.req_addr = 32'h102;
    ifr.req_size = 2'b10; ifr.req_sign = 1'b0; ifr.req_wdata = 32'd0;
    sb.push_back('{rd: 32'd0, err: 1'b1});
    @(posedge clk); #1;
    ifr.req_valid = 1'b0;
    chk1("rej_rsp_valid_latency", ifr.rsp_valid, 1'b1);
    chk1("rej_req_ready", ifr.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rej_hold_rsp_valid", ifr.rsp_valid, 1'b1);
    chk1("rej_hold_err", ifr.rsp_err, 1'b1);
    ifr.rsp_ready = 1'b1;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL rej_scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk32("rej_rdata", ifr.rsp_rdata, e.rd);
      chk1("rej_err", ifr.rsp_err, e.err);
    end
    @(posedge clk); #1;
    ifr.rsp_ready = 1'b0;
    chk1("rej_retired", ifr.rsp_valid, 1'b0);
    chk1("rej_req_ready_back", ifr.req_ready, 1'b1);
    @(negedge clk); #1;
    chk32("rej_wen_never_low", 32'(rej_wen_cnt - wen0), 32'd0);
    chk32("rej_addr_never_moved", 32'(rej_addr_cnt - addr0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the pipeline's memory stage and the byte-addressed data memory port (Addr/Size/load_extend_sign/DataIn/DataOut/active-low WEN).
- Accepts one request at a time over a valid/ready handshake and drives the memory port.
- Aligned accesses complete in one memory beat. Misaligned halfword/word accesses are split into sequential byte beats, with load data reassembled and extended.
- Returns the result over a valid/ready response handshake.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = reject them with rsp_err, no memory beat.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 halfword, 10/11 word.
- req_sign  in  1  load: 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, low bytes significant.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned access rejected (ALLOW_MISALIGNED=0).
- mem_addr  out  32  memory Addr.
- mem_size  out  2  memory Size.
- mem_sign  out  1  memory load_extend_sign.
- mem_wdata  out  32  memory DataIn.
- mem_wen_n  out  1  memory WEN, active-low.
- mem_rdata  in  32  memory DataOut (combinational read).

Behaviour:
- Handshake: request accepted at a posedge where req_valid & req_ready. Response retired at a posedge where rsp_valid & rsp_ready.
- States: IDLE, BEAT, RESP.
- IDLE: req_ready=1. On accept, latch all req_* fields and compute misalignment:
  - halfword: addr[0]≠0
  - word: addr[1:0]≠0
  - byte: never misaligned
- IDLE transitions on accept:
  - aligned → BEAT with beats=1.
  - misaligned and ALLOW_MISALIGNED=1 → BEAT with beats=2 (halfword) or 4 (word).
  - misaligned and ALLOW_MISALIGNED=0 → RESP with rsp_err=1, rdata=0.
- BEAT, aligned access:
  - Drive mem_addr=addr, mem_size=size, mem_sign=sign, mem_wdata=wdata.
  - mem_wen_n=~write for the whole cycle; memory commits the write on the falling edge.
  - Loads capture mem_rdata at the closing posedge.
- BEAT, split access, beat i (0..beats-1):
  - Drive mem_addr=addr+i (mod 2^32), mem_size=00, mem_sign=0, mem_wdata={24'b0, wdata byte i}, mem_wen_n=~write.
  - Loads capture mem_rdata[7:0] into lane i.
  - After the last beat, the assembled value is sign- or zero-extended from bit 15 (halfword) or passed through (word).
- Beat counter advances one per cycle. Last beat → RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - Retire → IDLE. req_ready=0 in BEAT and RESP; no overlap of requests.
- Outside BEAT, memory port idles: mem_wen_n=1, mem_addr=0, mem_size=00, mem_sign=0, mem_wdata=0.
- Latency: acceptance at edge N.
  - Aligned: single beat during cycle N→N+1; rsp_valid high from edge N+1.
  - Split: rsp_valid from edge N+beats.
  - Rejected: rsp_valid from edge N+1.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, memory port idle values.
- Reset mid-operation: state returns to IDLE at the posedge where RST=1.
  - Remaining beats are discarded; no response is produced.
  - A beat already in progress completes its falling-edge write, so a partially written split store is permitted.
- Store responses: rsp_rdata=0, rsp_err=0.

Decomposition:
- Shared package: SIZE_BYTE=2'b00, SIZE_HWORD=2'b01, SIZE_WORD=2'b10 constants; state encoding (IDLE/BEAT/RESP).
- One sub-module, lsu_load_assemble: combinational lane merge plus sign/zero extension from {size, sign, byte lanes}.

Test Plan:
- Memory preload 0x100..0x105 = 11,22,33,84,55,66; load word, addr 0x100 → one beat, mem_addr=0x100, mem_size=10, rsp_rdata=0x84332211, rsp_valid at edge N+1.
- Load byte at 0x103 with sign=1 → 0xFFFFFF84; with sign=0 → 0x00000084.
- Misaligned loads:
  - signed halfword at 0x101 → beats at 0x101, 0x102, rsp_rdata=0x00003322.
  - word at 0x102 → 4 beats 0x102..0x105, mem_size=00 each, rsp_rdata=0x66558433, rsp_valid at N+4.
- Misaligned store word 0xAABBCCDD at 0x201 → bytes DD,CC,BB,AA at 0x201..0x204; then load word 0x200 (0x200 preloaded 0x00) → 0xBBCCDD00.
- Backpressure and reject:
  - rsp_ready low 3 cycles → rsp_valid/rsp_rdata stable, req_ready=0, memory port idle.
  - ALLOW_MISALIGNED=0, load word at 0x102 → rsp_err=1, rsp_rdata=0, mem_wen_n never low, no mem_addr change.
- RST=1 during beat 2 of a split store at 0x301 → IDLE next edge, rsp_valid never asserted, only bytes 0x301, 0x302 written, next aligned request completes normally.
